// File: rtl/top_level.sv
`default_nettype none
// =============================================================================
// top_level : sequenced Hamming encode / correct / pattern-count engine
//             operating on a 256-byte internal data memory.
// Rev 1.0
// =============================================================================

module data_mem #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          i_clk,
  input  logic [AW-1:0] i_addr,
  input  logic          i_we,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] core [0:(1<<AW)-1];

  always_ff @(posedge i_clk) begin
    if (i_we) core[i_addr] <= i_wdata;
  end

  assign o_rdata = core[i_addr];
endmodule

module top_level #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic CLK,
  input  logic reset,
  input  logic start,
  output logic halt
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic [1:0]    r_prog;
  logic [5:0]    r_step;
  logic [7:0]    r_lo;
  logic [6:0]    r_hi;
  logic [3:0]    r_pat;
  logic [2:0]    r_prev;
  logic [7:0]    r_cnt_nib;
  logic [7:0]    r_cnt_str;
  logic [7:0]    r_cnt_byte;
  logic          r_halt;

  logic [AW-1:0] w_addr;
  logic          w_we;
  logic [DW-1:0] w_wdata;
  logic [DW-1:0] w_rdata;
  logic          w_last;

  data_mem #(.AW(AW), .DW(DW)) data_mem1 (
    .i_clk   (CLK),
    .i_addr  (w_addr),
    .i_we    (w_we),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  // Encoder: result bytes are the code word c[8:1] and c[15:9].
  logic [11:1] w_d;
  logic [7:0]  w_enc_lo;
  logic [7:0]  w_enc_hi;

  assign w_d      = {r_hi[2:0], r_lo};
  assign w_enc_hi = {1'b0, w_d[11:5]};
  assign w_enc_lo = {(^w_d[11:5]), w_d[4:2], ((^w_d[11:8]) ^ (^w_d[4:2])), w_d[1],
                     (w_d[11] ^ w_d[10] ^ w_d[7] ^ w_d[6] ^ w_d[4] ^ w_d[3] ^ w_d[1]),
                     (w_d[11] ^ w_d[9] ^ w_d[7] ^ w_d[5] ^ w_d[4] ^ w_d[2] ^ w_d[1])};

  // Decoder: syndrome is the XOR of set-bit positions; it names the bad bit.
  logic [15:1] w_c;
  logic [15:1] w_cc;
  logic [3:0]  w_syn;
  logic [7:0]  w_dec_lo;
  logic [7:0]  w_dec_hi;

  assign w_c = {r_hi, r_lo};

  always_comb begin
    w_syn = '0;
    w_cc  = w_c;
    for (int k = 1; k < 16; k++) begin
      if (w_c[k]) w_syn = w_syn ^ k[3:0];
    end
    for (int k = 1; k < 16; k++) begin
      w_cc[k] = w_c[k] ^ (w_syn == k[3:0]);
    end
  end

  assign w_dec_lo = {w_cc[12:9], w_cc[7:5], w_cc[3]};
  assign w_dec_hi = {5'b0, w_cc[15:13]};

  // Pattern counter: windows k=0..4 lie inside the byte, k=5..7 straddle
  // the previous byte's low bits (absent for the first byte of the stream).
  logic [10:0] w_win;
  logic [2:0]  w_in_cnt;
  logic [1:0]  w_x_cnt;

  assign w_win = {r_prev, w_rdata};

  always_comb begin
    w_in_cnt = '0;
    w_x_cnt  = '0;
    for (int k = 0; k < 5; k++) begin
      if (w_win[k +: 4] == r_pat) w_in_cnt = w_in_cnt + 3'd1;
    end
    for (int k = 5; k < 8; k++) begin
      if ((w_win[k +: 4] == r_pat) && (r_step != 6'd1)) w_x_cnt = w_x_cnt + 2'd1;
    end
  end

  assign w_last = (r_prog == 2'd3) ? (r_step == 6'd35) : (r_step == 6'd59);

  // Programs 1/2: step = {word, phase}; phases read lo, read hi, write lo, write hi.
  always_comb begin
    w_addr  = '0;
    w_we    = 1'b0;
    w_wdata = '0;
    if (r_state == S_RUN) begin
      if (r_prog == 2'd3) begin
        if (r_step == 6'd0) begin
          w_addr = 8'd160;
        end else if (r_step <= 6'd32) begin
          w_addr = 8'd127 + {2'b0, r_step};
        end else begin
          w_we = 1'b1;
          case (r_step)
            6'd33:   begin w_addr = 8'd192; w_wdata = r_cnt_nib;  end
            6'd34:   begin w_addr = 8'd193; w_wdata = r_cnt_str;  end
            default: begin w_addr = 8'd194; w_wdata = r_cnt_byte; end
          endcase
        end
      end else begin
        if (r_prog == 2'd2) w_addr = r_step[1] ? 8'd94 : 8'd64;
        else                w_addr = r_step[1] ? 8'd30 : 8'd0;
        w_addr = w_addr + {3'b0, r_step[5:2], r_step[0]};
        w_we   = r_step[1];
        if (r_prog == 2'd2) w_wdata = r_step[0] ? w_dec_hi : w_dec_lo;
        else                w_wdata = r_step[0] ? w_enc_hi : w_enc_lo;
      end
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_prog     <= 2'd1;
      r_step     <= '0;
      r_lo       <= '0;
      r_hi       <= '0;
      r_pat      <= '0;
      r_prev     <= '0;
      r_cnt_nib  <= '0;
      r_cnt_str  <= '0;
      r_cnt_byte <= '0;
      r_halt     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= S_RUN;
            r_halt  <= 1'b0;
            r_step  <= '0;
          end
        end
        S_RUN: begin
          r_step <= r_step + 6'd1;
          if (r_prog == 2'd3) begin
            if (r_step == 6'd0) begin
              r_pat      <= w_rdata[3:0];
              r_prev     <= '0;
              r_cnt_nib  <= '0;
              r_cnt_str  <= '0;
              r_cnt_byte <= '0;
            end else if (r_step <= 6'd32) begin
              r_prev     <= w_rdata[2:0];
              r_cnt_nib  <= r_cnt_nib + {5'b0, w_in_cnt};
              r_cnt_str  <= r_cnt_str + {5'b0, w_in_cnt} + {6'b0, w_x_cnt};
              r_cnt_byte <= r_cnt_byte + {7'b0, (w_in_cnt != 3'd0)};
            end
          end else begin
            if (r_step[1:0] == 2'd0) r_lo <= w_rdata;
            if (r_step[1:0] == 2'd1) r_hi <= w_rdata[6:0];
          end
          if (w_last) begin
            r_state <= S_DONE;
            r_halt  <= 1'b1;
            r_prog  <= (r_prog == 2'd3) ? 2'd1 : r_prog + 2'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign halt = r_halt;
endmodule
`default_nettype wire

// File: tb/tb_top_level.sv
`default_nettype none
// tb_top_level : scoreboard bench; expected memory results are queued per run
//                and checked by a monitor when halt rises.
module tb_top_level;
  logic CLK   = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic halt;

  int n_vec = 0;
  int n_err = 0;
  int lat_p1;
  int lat;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    bit         last;
  } exp_t;
  exp_t sb[$];

  localparam logic [7:0] P1_IN  [10] = '{8'h55, 8'h05, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h04};
  localparam logic [7:0] P1_OUT [10] = '{8'h2D, 8'h55, 8'h00, 8'h00, 8'hFF, 8'h7F, 8'h07, 8'h00, 8'h8B, 8'h40};
  localparam logic [7:0] P2_IN  [12] = '{8'h3D, 8'h55, 8'h2D, 8'h55, 8'h2D, 8'h15, 8'h8B, 8'hC0, 8'h06, 8'h00, 8'h80, 8'h00};
  localparam logic [7:0] P2_OUT [12] = '{8'h55, 8'h05, 8'h55, 8'h05, 8'h55, 8'h05, 8'h00, 8'h04, 8'h01, 8'h00, 8'h00, 8'h00};

  top_level #(.AW(8), .DW(8)) dut (
    .CLK   (CLK),
    .reset (reset),
    .start (start),
    .halt  (halt)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic mem_wr(input int a, input logic [7:0] v);
    dut.data_mem1.core[a] = v;
  endtask

  function automatic logic [7:0] mem_rd(input int a);
    return dut.data_mem1.core[a];
  endfunction

  task automatic push_exp(input int a, input logic [7:0] v, input bit last);
    exp_t e;
    e.addr = a[7:0];
    e.data = v;
    e.last = last;
    sb.push_back(e);
  endtask

  // Start handshake; latency counts edges after the accepting edge.
  task automatic pulse_start(input int hold, output int latency);
    int el;
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    check("halt_low_after_start", {31'b0, halt}, 32'd0);
    el = 0;
    for (int h = 1; h < hold; h++) begin
      @(negedge CLK);
      el++;
    end
    start = 1'b0;
    while (!halt && el < 200) begin
      @(negedge CLK);
      el++;
    end
    if (!halt) begin
      n_vec++;
      n_err++;
      $display("FAIL halt_timeout: halt=0 after %0d cycles, required 1", el);
    end
    latency = el;
  endtask

  task automatic run_p1(input int hold, output int latency);
    @(negedge CLK);
    for (int i = 0; i < 30; i++) begin
      mem_wr(i, (i < 10) ? P1_IN[i] : 8'h00);
      mem_wr(30 + i, 8'hAA);
    end
    for (int i = 0; i < 30; i++) push_exp(30 + i, (i < 10) ? P1_OUT[i] : 8'h00, i == 29);
    pulse_start(hold, latency);
  endtask

  task automatic run_p2(output int latency);
    @(negedge CLK);
    for (int i = 0; i < 30; i++) begin
      mem_wr(64 + i, (i < 12) ? P2_IN[i] : 8'h00);
      mem_wr(94 + i, 8'hAA);
    end
    for (int i = 0; i < 30; i++) push_exp(94 + i, (i < 12) ? P2_OUT[i] : 8'h00, i == 29);
    pulse_start(1, latency);
  endtask

  task automatic run_p3(input logic [7:0] fill, input logic [7:0] pat,
                        input logic [7:0] e_nib, input logic [7:0] e_str, input logic [7:0] e_byte);
    int latency;
    @(negedge CLK);
    for (int i = 128; i < 160; i++) mem_wr(i, fill);
    mem_wr(160, pat);
    for (int i = 192; i < 195; i++) mem_wr(i, 8'hAA);
    push_exp(192, e_nib, 1'b0);
    push_exp(193, e_str, 1'b0);
    push_exp(194, e_byte, 1'b1);
    pulse_start(1, latency);
  endtask

  // Monitor: on each rising halt, pop one run's worth of expectations.
  initial begin : monitor
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge CLK);
      if (halt && !prev) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_halt: halt=1 with no queued results, required 0");
        end else begin
          do begin
            e = sb.pop_front();
            check($sformatf("core[%0d]", e.addr), {24'b0, mem_rd(int'(e.addr))}, {24'b0, e.data});
          end while (!e.last && sb.size() > 0);
        end
      end
      prev = halt;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    reset = 1'b1;
    repeat (3) @(negedge CLK);
    check("reset_halt", {31'b0, halt}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("idle_halt", {31'b0, halt}, 32'd0);
    end

    // Interrupt a program-1 run with reset; select must return to program 1.
    for (int i = 0; i < 10; i++) mem_wr(i, P1_IN[i]);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (10) @(negedge CLK);
    #2 reset = 1'b1;
    #1 check("reset_mid_run_halt", {31'b0, halt}, 32'd0);
    @(negedge CLK);
    reset = 1'b0;

    run_p1(1, lat_p1);
    run_p2(lat);
    run_p3(8'h55, 8'h05, 8'd96, 8'd127, 8'd32);
    run_p1(20, lat);
    check("held_start_latency", lat, lat_p1);
    run_p2(lat);
    run_p3(8'h00, 8'hF0, 8'd160, 8'd253, 8'd32);
    run_p1(1, lat);
    run_p2(lat);
    run_p3(8'h00, 8'h0F, 8'd0, 8'd0, 8'd0);

    repeat (5) @(negedge CLK);
    check("halt_held_in_done", {31'b0, halt}, 32'd1);
    #2 reset = 1'b1;
    #1 check("async_reset_halt", {31'b0, halt}, 32'd0);
    @(negedge CLK);
    reset = 1'b0;
    @(negedge CLK);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
